// File: rtl/d2d_tx_mux_if.sv
// Bundle between the D2D transmit mux, its input channels, the upstream arbiter and the link.
// The slave modport is the mux's view of the bundle; the master modport is the surrounding logic's view.
interface d2d_tx_mux_if #(
  parameter int CHANNELS   = 2,
  parameter int FLIT_WIDTH = 64
);
  localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [CHANNELS*FLIT_WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]            in_last;
  logic [CHANNELS-1:0]            in_valid;
  logic [CHANNELS-1:0]            in_ready;
  logic [CHANNELS-1:0]            arb_request;
  logic [IDX_W-1:0]               arb_grant_index;
  logic                           arb_grant_valid;
  logic                           arb_accept;
  logic [FLIT_WIDTH-1:0]          out_data;
  logic [IDX_W-1:0]               out_chan;
  logic                           out_last;
  logic                           out_valid;
  logic                           credit_return;
  logic                           credit_overflow;

  modport master (
    output in_data, in_last, in_valid, arb_grant_index, arb_grant_valid, credit_return,
    input  in_ready, arb_request, arb_accept, out_data, out_chan, out_last, out_valid,
           credit_overflow
  );

  modport slave (
    input  in_data, in_last, in_valid, arb_grant_index, arb_grant_valid, credit_return,
    output in_ready, arb_request, arb_accept, out_data, out_chan, out_last, out_valid,
           credit_overflow
  );
endinterface

// File: rtl/d2d_tx_mux.sv
// Die-to-die transmit mux: requests grants from the arbiter, forwards the granted flit onto
// a registered link, holds a wormhole lock per packet and throttles on far-die credits.
module d2d_tx_mux #(
  parameter int CHANNELS   = 2,
  parameter int FLIT_WIDTH = 64,
  parameter int CREDITS    = 8
) (
  input logic            clk,
  input logic            rst,
  d2d_tx_mux_if.slave    bus
);
  localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int CNT_W = $clog2(CREDITS + 1);
  localparam logic [CNT_W-1:0] CREDITS_C = CNT_W'(CREDITS);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t                state_r;
  state_t                state_nxt_s;
  logic [IDX_W-1:0]      lock_ch_r;
  logic [IDX_W-1:0]      lock_ch_nxt_s;
  logic [CNT_W-1:0]      credit_cnt_r;
  logic [CNT_W-1:0]      credit_cnt_nxt_s;
  logic                  overflow_set_s;
  logic                  credit_ok_s;
  logic                  fire_s;
  logic [CHANNELS-1:0]   lock_mask_s;
  logic [CHANNELS-1:0]   arb_req_s;
  logic [CHANNELS-1:0]   in_ready_s;
  logic [FLIT_WIDTH-1:0] grant_data_s;
  logic                  grant_last_s;

  logic [FLIT_WIDTH-1:0] out_data_r;
  logic [IDX_W-1:0]      out_chan_r;
  logic                  out_last_r;
  logic                  out_valid_r;
  logic                  credit_overflow_r;

  assign credit_ok_s = (credit_cnt_r != {CNT_W{1'b0}});
  // A grant arriving without credit is dropped here rather than trusted from the arbiter.
  assign fire_s      = bus.arb_grant_valid & credit_ok_s;

  // Select the granted channel's flit and build the lock mask and per-channel ready.
  always_comb begin
    grant_data_s = {FLIT_WIDTH{1'b0}};
    grant_last_s = 1'b0;
    lock_mask_s  = {CHANNELS{1'b0}};
    in_ready_s   = {CHANNELS{1'b0}};
    for (int i = 0; i < CHANNELS; i++) begin
      if (bus.arb_grant_index == IDX_W'(i)) begin
        grant_data_s  = bus.in_data[i*FLIT_WIDTH +: FLIT_WIDTH];
        grant_last_s  = bus.in_last[i];
        in_ready_s[i] = fire_s;
      end else begin
        in_ready_s[i] = 1'b0;
      end
      lock_mask_s[i] = (lock_ch_r == IDX_W'(i));
    end
  end

  // Request generation: all valid channels when idle, only the locked one mid-packet.
  always_comb begin
    arb_req_s = bus.in_valid & {CHANNELS{credit_ok_s}};
    if (state_r == ST_LOCKED) begin
      arb_req_s = arb_req_s & lock_mask_s;
    end else begin
      arb_req_s = bus.in_valid & {CHANNELS{credit_ok_s}};
    end
  end

  assign bus.arb_request = arb_req_s;
  assign bus.arb_accept  = fire_s;
  assign bus.in_ready    = in_ready_s;

  // Wormhole lock next-state.
  always_comb begin
    state_nxt_s   = state_r;
    lock_ch_nxt_s = lock_ch_r;
    case (state_r)
      ST_IDLE: begin
        if (fire_s && !grant_last_s) begin
          state_nxt_s   = ST_LOCKED;
          lock_ch_nxt_s = bus.arb_grant_index;
        end else begin
          state_nxt_s   = ST_IDLE;
        end
      end
      ST_LOCKED: begin
        if (fire_s && grant_last_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_LOCKED;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Credit counter next value; a return with a full counter is an overflow, not a wrap.
  always_comb begin
    credit_cnt_nxt_s = credit_cnt_r;
    overflow_set_s   = 1'b0;
    if (fire_s && !bus.credit_return) begin
      credit_cnt_nxt_s = credit_cnt_r - CNT_W'(1);
    end else if (!fire_s && bus.credit_return) begin
      if (credit_cnt_r == CREDITS_C) begin
        overflow_set_s = 1'b1;
      end else begin
        credit_cnt_nxt_s = credit_cnt_r + CNT_W'(1);
      end
    end else begin
      credit_cnt_nxt_s = credit_cnt_r;
    end
  end

  // State, credit and link output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r           <= ST_IDLE;
      lock_ch_r         <= {IDX_W{1'b0}};
      credit_cnt_r      <= CREDITS_C;
      credit_overflow_r <= 1'b0;
      out_valid_r       <= 1'b0;
      out_data_r        <= {FLIT_WIDTH{1'b0}};
      out_chan_r        <= {IDX_W{1'b0}};
      out_last_r        <= 1'b0;
    end else begin
      state_r           <= state_nxt_s;
      lock_ch_r         <= lock_ch_nxt_s;
      credit_cnt_r      <= credit_cnt_nxt_s;
      credit_overflow_r <= credit_overflow_r | overflow_set_s;
      out_valid_r       <= fire_s;
      if (fire_s) begin
        out_data_r <= grant_data_s;
        out_chan_r <= bus.arb_grant_index;
        out_last_r <= grant_last_s;
      end else begin
        out_data_r <= out_data_r;
        out_chan_r <= out_chan_r;
        out_last_r <= out_last_r;
      end
    end
  end

  assign bus.out_data        = out_data_r;
  assign bus.out_chan        = out_chan_r;
  assign bus.out_last        = out_last_r;
  assign bus.out_valid       = out_valid_r;
  assign bus.credit_overflow = credit_overflow_r;
endmodule

// File: tb/tb_d2d_tx_mux.sv
// Bench for d2d_tx_mux: directed scenarios then random traffic, checked each cycle against a
// queue-based reference model with a round-robin arbiter stand-in.
module tb_d2d_tx_mux;
  localparam int CH = 2;
  localparam int FW = 64;
  localparam int CR = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  d2d_tx_mux_if #(.CHANNELS(CH), .FLIT_WIDTH(FW)) bus();

  d2d_tx_mux #(.CHANNELS(CH), .FLIT_WIDTH(FW), .CREDITS(CR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Pending flits per channel, {last, data}.
  logic [FW:0]   q [CH][$];
  logic [CH-1:0] en;
  logic          force_gv;
  int            stub_ptr;

  // Reference model state.
  int            m_cred;
  int            m_lock;
  int            m_rr;
  bit            m_ov;
  bit            m_ovf;
  logic [FW-1:0] m_od;
  int            m_oc;
  bit            m_ol;

  function automatic int rr_pick(logic [CH-1:0] req, int ptr);
    for (int k = 0; k < CH; k++) begin
      int c;
      c = (ptr + k) % CH;
      if (req[c]) return c;
    end
    return -1;
  endfunction

  // Arbiter stand-in: round robin starting after the last accepted grant.
  always_comb begin
    int p;
    p = rr_pick(bus.arb_request, stub_ptr);
    bus.arb_grant_valid = 1'b0;
    bus.arb_grant_index = 1'b0;
    if (force_gv) begin
      bus.arb_grant_valid = 1'b1;
      bus.arb_grant_index = 1'b0;
    end else if (p >= 0) begin
      bus.arb_grant_valid = 1'b1;
      bus.arb_grant_index = p[0];
    end
  end

  always @(posedge clk) begin
    if (rst) stub_ptr <= 0;
    else if (bus.arb_accept) stub_ptr <= (int'(bus.arb_grant_index) + 1) % CH;
  end

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check combinational handshake, advance, check registers.
  task automatic step(bit cr);
    logic [CH-1:0]    v, exp_req, exp_rdy;
    logic [CH*FW-1:0] d;
    logic [CH-1:0]    l;
    int  gi;
    bit  gv, fire;
    for (int i = 0; i < CH; i++) begin
      v[i] = (q[i].size() > 0) && en[i];
      d[i*FW +: FW] = (q[i].size() > 0) ? q[i][0][FW-1:0] : {FW{1'b0}};
      l[i] = (q[i].size() > 0) ? q[i][0][FW] : 1'b0;
    end
    bus.in_valid = v;
    bus.in_data = d;
    bus.in_last = l;
    bus.credit_return = cr;
    #2;
    for (int i = 0; i < CH; i++)
      exp_req[i] = v[i] && (m_cred != 0) && (m_lock < 0 || m_lock == i);
    if (force_gv) begin
      gi = 0;
      gv = 1'b1;
    end else begin
      gi = rr_pick(exp_req, m_rr);
      gv = (gi >= 0);
    end
    fire = gv && (m_cred != 0);
    exp_rdy = '0;
    if (fire) exp_rdy[gi] = 1'b1;
    chk("arb_request", bus.arb_request, exp_req);
    chk("arb_accept", bus.arb_accept, fire);
    chk("in_ready", bus.in_ready, exp_rdy);
    if (rst) begin
      m_ov = 0; m_od = '0; m_oc = 0; m_ol = 0;
      m_cred = CR; m_ovf = 0; m_lock = -1; m_rr = 0;
    end else begin
      m_ov = fire;
      if (fire) begin
        m_od = q[gi][0][FW-1:0];
        m_ol = q[gi][0][FW];
        m_oc = gi;
        m_lock = m_ol ? -1 : gi;
        m_rr = (gi + 1) % CH;
      end
      if (fire && !cr) m_cred = m_cred - 1;
      else if (cr && !fire) begin
        if (m_cred == CR) m_ovf = 1;
        else m_cred = m_cred + 1;
      end
    end
    @(posedge clk);
    if (fire && !rst) void'(q[gi].pop_front());
    #1;
    chk("out_valid", bus.out_valid, m_ov);
    chk("out_data", bus.out_data, m_od);
    chk("out_chan", bus.out_chan, m_oc);
    chk("out_last", bus.out_last, m_ol);
    chk("credit_cnt", dut.credit_cnt_r, m_cred);
    chk("credit_overflow", bus.credit_overflow, m_ovf);
  endtask

  task automatic push_pkt(int ch, int len, logic [FW-1:0] base);
    for (int k = 0; k < len; k++) q[ch].push_back({(k == len - 1), base + FW'(k)});
  endtask

  task automatic run_until_empty(int budget, bit cr);
    int n;
    n = 0;
    while ((q[0].size() > 0 || q[1].size() > 0) && n < budget) begin
      step(cr);
      n++;
    end
    chk("drain_timeout", (n < budget), 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    en = '1;
    force_gv = 1'b0;
    bus.in_valid = '0;
    bus.in_data = '0;
    bus.in_last = '0;
    bus.credit_return = 1'b0;
    m_cred = CR; m_lock = -1; m_rr = 0; m_ov = 0; m_ovf = 0; m_od = '0; m_oc = 0; m_ol = 0;

    // Reset state.
    step(1'b0);
    step(1'b0);
    rst = 1'b0;

    // Single-flit packet on ch0.
    push_pkt(0, 1, 64'hA5);
    step(1'b0);
    chk("t1_credit", dut.credit_cnt_r, 4'd7);
    step(1'b0);

    // 3-flit ch0 packet with ch1 competing once ch0 is locked.
    push_pkt(0, 3, 64'h10);
    step(1'b0);
    push_pkt(1, 2, 64'h20);
    run_until_empty(20, 1'b0);

    // Credit exhaustion with alternating single-flit packets.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      push_pkt(0, 1, 64'h100 + 64'(k));
      push_pkt(1, 1, 64'h200 + 64'(k));
    end
    repeat (12) step(1'b0);
    chk("t3_credit_zero", dut.credit_cnt_r, 4'd0);
    chk("t3_left", q[0].size() + q[1].size(), 2);
    force_gv = 1'b1;
    step(1'b0);
    force_gv = 1'b0;

    // One credit returned yields exactly one more flit.
    step(1'b1);
    repeat (3) step(1'b0);
    chk("t4_left", q[0].size() + q[1].size(), 1);
    run_until_empty(20, 1'b1);

    // Fire and credit return together.
    do_reset();
    push_pkt(0, 1, 64'h30); push_pkt(0, 1, 64'h31);
    push_pkt(0, 1, 64'h32); push_pkt(0, 1, 64'h33);
    repeat (3) step(1'b0);
    step(1'b1);
    chk("t5_credit_hold", dut.credit_cnt_r, 4'd5);

    // Return at full credit.
    do_reset();
    step(1'b1);
    chk("t6_overflow", bus.credit_overflow, 1'b1);
    chk("t6_credit", dut.credit_cnt_r, 4'd8);
    step(1'b0);

    // Reset in the middle of a packet.
    do_reset();
    push_pkt(0, 4, 64'h40);
    step(1'b0);
    step(1'b0);
    q[0].delete();
    rst = 1'b1;
    step(1'b0);
    rst = 1'b0;
    chk("t7_valid", bus.out_valid, 1'b0);
    chk("t7_credit", dut.credit_cnt_r, 4'd8);
    push_pkt(1, 1, 64'h50);
    step(1'b0);
    chk("t7_ch1", bus.out_chan, 1'b1);
    push_pkt(0, 1, 64'h60);
    push_pkt(1, 1, 64'h61);
    step(1'b0);

    // Random traffic.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < CH; i++) begin
        if (q[i].size() == 0 && $urandom_range(0, 2) == 0)
          push_pkt(i, $urandom_range(1, 4), {$urandom, $urandom});
        en[i] = ($urandom_range(0, 4) != 0);
      end
      force_gv = (m_cred == 0) && ($urandom_range(0, 3) == 0);
      step($urandom_range(0, 99) < 45);
      force_gv = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
